// File: rtl/sel_enc164.sv
// Vending selection encoder: synchronises and debounces 16 select buttons,
// priority-encodes the press and offers one code per press over valid/ready.
module sel_enc164 #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] btn,
  input  logic        ready,
  output logic [3:0]  code,
  output logic        valid,
  output logic        multi
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    OFFER,
    RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             multi_q, multi_d;

  logic [15:0] btn_s;
  logic [3:0]  low_idx;
  logic        many;
  logic        any;

  assign btn_s = sync2_q;
  assign any   = |btn_s;
  // more than one bit set: clearing the lowest set bit leaves something
  assign many  = |(btn_s & (btn_s - 16'd1));

  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (btn_s[i]) low_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = valid_q;
    multi_d = multi_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          cand_d  = low_idx;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!btn_s[cand_q]) begin
          state_d = IDLE;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // code is transmitted MSB in bit 0
          code_d  = {cand_q[0], cand_q[1], cand_q[2], cand_q[3]};
          multi_d = many;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (any) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= btn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule
